// File: rtl/fft_stage_scheduler.sv
// Sequencer for the in-place radix-2 DIT FFT: bit-reversal swaps, then log2(N) butterfly
// stages, separated by drain gaps of BF_LATENCY cycles, ending in a calc-end level.
module fft_stage_scheduler #(
    parameter int ADDR_W     = 12,
    parameter int BF_LATENCY = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_DATA_LOADED,
    input  logic [ADDR_W-1:0] i_SAMPLES_NUMBER,
    input  logic              i_BF_READY,
    output logic              o_SWAP_VALID,
    output logic              o_BF_VALID,
    output logic [ADDR_W-1:0] o_ADDR_A,
    output logic [ADDR_W-1:0] o_ADDR_B,
    output logic [ADDR_W-2:0] o_TWIDDLE_IDX,
    output logic [3:0]        o_STAGE,
    output logic              o_BUSY,
    output logic              o_CALC_END,
    output logic              o_ERR
);

    localparam int GAP_W = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BF_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BITREV,
        S_GAP,
        S_STAGE,
        S_DONE
    } state_t;

    function automatic logic n_ok(input logic [ADDR_W-1:0] n);
        return (n > ADDR_W'(1)) && ((n & (n - ADDR_W'(1))) == '0);
    endfunction

    function automatic logic [3:0] log2_enc(input logic [ADDR_W-1:0] n);
        logic [3:0] m;
        m = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            if (n[b]) m = b[3:0];
        end
        return m;
    endfunction

    // Full-width mirror, then shift the reversed field down to M bits.
    function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] idx,
                                                 input logic [3:0]        m);
        logic [ADDR_W-1:0] full;
        for (int b = 0; b < ADDR_W; b++) begin
            full[b] = idx[ADDR_W-1-b];
        end
        return full >> (ADDR_W - int'(m));
    endfunction

    function automatic logic [ADDR_W-1:0] bf_addr_a(input logic [ADDR_W-1:0] k,
                                                   input logic [3:0]        s);
        logic [ADDR_W-1:0] pos;
        logic [ADDR_W-1:0] grp;
        pos = k & ((ADDR_W'(1) << s) - ADDR_W'(1));
        grp = k >> s;
        return (grp << (s + 4'd1)) | pos;
    endfunction

    function automatic logic [ADDR_W-2:0] tw_idx(input logic [ADDR_W-1:0] k,
                                                input logic [3:0]        s,
                                                input logic [3:0]        m);
        logic [ADDR_W-1:0] pos;
        logic [ADDR_W-1:0] sh;
        pos = k & ((ADDR_W'(1) << s) - ADDR_W'(1));
        sh  = pos << (m - 4'd1 - s);
        return sh[ADDR_W-2:0];
    endfunction

    state_t            r_state;
    logic [ADDR_W-1:0] r_n;
    logic [3:0]        r_m;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_k;
    logic [3:0]        r_s;
    logic [GAP_W-1:0]  r_gap;
    logic              r_swap_valid;
    logic              r_bf_valid;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [ADDR_W-2:0] r_tw;
    logic [3:0]        r_stage;
    logic              r_busy;
    logic              r_calc_end;
    logic              r_err;

    logic [ADDR_W-1:0] w_rev;
    logic [ADDR_W-1:0] w_bf_a;
    logic [ADDR_W-1:0] w_bf_b;
    logic [ADDR_W-2:0] w_tw;
    logic [ADDR_W-1:0] w_half_n;

    // r_k always holds the index of the next butterfly to be loaded (0 while in GAP).
    assign w_rev    = bit_rev(r_i, r_m);
    assign w_bf_a   = bf_addr_a(r_k, r_s);
    assign w_bf_b   = w_bf_a + (ADDR_W'(1) << r_s);
    assign w_tw     = tw_idx(r_k, r_s, r_m);
    assign w_half_n = r_n >> 1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_m          <= '0;
            r_i          <= '0;
            r_k          <= '0;
            r_s          <= '0;
            r_gap        <= '0;
            r_swap_valid <= 1'b0;
            r_bf_valid   <= 1'b0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_tw         <= '0;
            r_stage      <= '0;
            r_busy       <= 1'b0;
            r_calc_end   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_DATA_LOADED) begin
                        r_calc_end <= 1'b0;
                        if (n_ok(i_SAMPLES_NUMBER)) begin
                            r_n     <= i_SAMPLES_NUMBER;
                            r_m     <= log2_enc(i_SAMPLES_NUMBER);
                            r_i     <= '0;
                            r_s     <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_BITREV;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                // One index evaluated per cycle unless a swap is waiting for acceptance.
                S_BITREV: begin
                    if (!r_swap_valid || i_BF_READY) begin
                        if (r_i == r_n) begin
                            r_swap_valid <= 1'b0;
                            r_gap        <= '0;
                            r_k          <= '0;
                            r_state      <= S_GAP;
                        end else begin
                            r_swap_valid <= (r_i < w_rev);
                            r_addr_a     <= r_i;
                            r_addr_b     <= w_rev;
                            r_i          <= r_i + ADDR_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        if (r_s == r_m) begin
                            r_busy     <= 1'b0;
                            r_calc_end <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_bf_valid <= 1'b1;
                            r_addr_a   <= w_bf_a;
                            r_addr_b   <= w_bf_b;
                            r_tw       <= w_tw;
                            r_stage    <= r_s;
                            r_k        <= r_k + ADDR_W'(1);
                            r_state    <= S_STAGE;
                        end
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                S_STAGE: begin
                    if (i_BF_READY) begin
                        if (r_k == w_half_n) begin
                            r_bf_valid <= 1'b0;
                            r_stage    <= '0;
                            r_s        <= r_s + 4'd1;
                            r_gap      <= '0;
                            r_k        <= '0;
                            r_state    <= S_GAP;
                        end else begin
                            r_addr_a <= w_bf_a;
                            r_addr_b <= w_bf_b;
                            r_tw     <= w_tw;
                            r_k      <= r_k + ADDR_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_SWAP_VALID  = r_swap_valid;
    assign o_BF_VALID    = r_bf_valid;
    assign o_ADDR_A      = r_addr_a;
    assign o_ADDR_B      = r_addr_b;
    assign o_TWIDDLE_IDX = r_tw;
    assign o_STAGE       = r_stage;
    assign o_BUSY        = r_busy;
    assign o_CALC_END    = r_calc_end;
    assign o_ERR         = r_err;

endmodule
